// File: rtl/mem_access_pkg.sv
// Shared types and defaults for the memory access controller: FSM states,
// grant-source encoding and vector addresses.
package mem_access_pkg;

    localparam int         STARVE_W         = 4;
    localparam logic [7:0] RST_VEC_ADDR_DEF = 8'h00;
    localparam logic [7:0] INT_VEC_ADDR_DEF = 8'h01;

    typedef enum logic [1:0] {
        RST_RD = 2'd0,
        RST_LD = 2'd1,
        RUN    = 2'd2,
        INT_LD = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_IF   = 2'd1,
        SRC_DM   = 2'd2,
        SRC_VEC  = 2'd3
    } gnt_src_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Fetch and data request/grant channels between the pipeline (master) and
// the memory access controller (slave).
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic              stall_if;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic              stall_mem;

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        input  if_gnt, if_rvalid, stall_if, dm_gnt, dm_rvalid, stall_mem
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        output if_gnt, if_rvalid, stall_if, dm_gnt, dm_rvalid, stall_mem
    );
endinterface

// File: rtl/mem_arb_prio.sv
// Data-over-fetch priority with a starvation counter that forces a fetch
// grant after MAX_STARVE consecutive denials.
module mem_arb_prio
    import mem_access_pkg::*;
#(
    parameter int MAX_STARVE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic if_req,
    input  logic hlt,
    input  logic dm_req,
    output logic if_gnt,
    output logic dm_gnt
);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_STARVE);

    logic [STARVE_W-1:0] starve_cnt;
    logic                fetch_ok;
    logic                force_if;

    always_comb begin
        fetch_ok = if_req & ~hlt;
        force_if = fetch_ok & (starve_cnt == STARVE_MAX);
        dm_gnt   = arb_en & dm_req & ~force_if;
        if_gnt   = arb_en & fetch_ok & ~dm_gnt;
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (if_gnt || !if_req) begin
            starve_cnt <= '0;
        end else if (!hlt && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Shares the unified memory between fetch and data, and runs the reset and
// interrupt vector fetches. Define MEM_ACCESS_STATS_EN for usage counters.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int                ADDR_W       = 8,
    parameter int                DATA_W       = 8,
    parameter int                MAX_STARVE   = 4,
    parameter logic [ADDR_W-1:0] RST_VEC_ADDR = ADDR_W'(RST_VEC_ADDR_DEF),
    parameter logic [ADDR_W-1:0] INT_VEC_ADDR = ADDR_W'(INT_VEC_ADDR_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_ctrl_if.slave  bus,
    input  logic              hlt,
    input  logic              int_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEM_ACCESS_STATS_EN
    output logic [15:0]       stat_if_stall,
    output logic [15:0]       stat_dm_acc,
    output logic [7:0]        stat_int,
`endif
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_vec,
    output logic              int_ack
);

    state_e            state;
    gnt_src_e          src;
    logic              int_pend;
    logic              vec_issue;
    logic              arb_en;
    logic              if_gnt;
    logic              dm_gnt;
    logic [ADDR_W-1:0] addr_q;

    assign vec_issue = (state == RUN) & int_pend & ~bus.dm_req;
    assign arb_en    = (state == RUN) & ~vec_issue;

    mem_arb_prio #(
        .MAX_STARVE (MAX_STARVE)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .arb_en (arb_en),
        .if_req (bus.if_req),
        .hlt    (hlt),
        .dm_req (bus.dm_req),
        .if_gnt (if_gnt),
        .dm_gnt (dm_gnt)
    );

    always_comb begin
        src = SRC_NONE;
        if (state == RST_RD || vec_issue) src = SRC_VEC;
        else if (dm_gnt)                  src = SRC_DM;
        else if (if_gnt)                  src = SRC_IF;
    end

    // NOTE: defaults first in always_comb so no path leaves an output unassigned (no latch).
    always_comb begin
        mem_addr = addr_q;
        mem_we   = 1'b0;
        case (src)
            SRC_VEC: mem_addr = (state == RST_RD) ? RST_VEC_ADDR : INT_VEC_ADDR;
            SRC_DM: begin
                mem_addr = bus.dm_addr;
                mem_we   = bus.dm_we;
            end
            SRC_IF:  mem_addr = bus.if_addr;
            default: ;
        endcase
    end

    assign mem_wdata     = bus.dm_wdata;
    assign bus.if_gnt    = if_gnt;
    assign bus.dm_gnt    = dm_gnt;
    assign bus.stall_if  = (bus.if_req & ~if_gnt) | (state != RUN) | vec_issue;
    assign bus.stall_mem = bus.dm_req & ~dm_gnt;
    assign int_ack       = vec_issue;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RST_RD;
            int_pend      <= 1'b0;
            addr_q        <= '0;
            pc_load       <= 1'b0;
            pc_vec        <= '0;
            bus.if_rvalid <= 1'b0;
            bus.dm_rvalid <= 1'b0;
        end else begin
            pc_load       <= 1'b0;
            bus.if_rvalid <= if_gnt;
            bus.dm_rvalid <= dm_gnt & ~bus.dm_we;
            // A new request arriving in the issue cycle is absorbed by the one being serviced.
            int_pend      <= vec_issue ? 1'b0 : (int_pend | int_in);
            if (src != SRC_NONE) addr_q <= mem_addr;

            case (state)
                RST_RD: state <= RST_LD;
                RST_LD, INT_LD: begin
                    pc_vec  <= ADDR_W'(mem_rdata);
                    pc_load <= 1'b1;
                    state   <= RUN;
                end
                RUN:     if (vec_issue) state <= INT_LD;
                default: state <= RST_RD;
            endcase
        end
    end

`ifdef MEM_ACCESS_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_if_stall <= '0;
            stat_dm_acc   <= '0;
            stat_int      <= '0;
        end else begin
            if (bus.stall_if && bus.if_req && stat_if_stall != '1) stat_if_stall <= stat_if_stall + 1'b1;
            if (dm_gnt && stat_dm_acc != '1)                       stat_dm_acc   <= stat_dm_acc + 1'b1;
            if (vec_issue && stat_int != '1)                       stat_int      <= stat_int + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model of the controller.
module tb_mem_access_ctrl;

    localparam int         MAX_STARVE = 4;
    localparam logic [7:0] RST_VEC    = 8'h00;
    localparam logic [7:0] INT_VEC    = 8'h01;

    typedef struct packed {
        logic       rst;
        logic       if_req;
        logic [7:0] if_addr;
        logic       dm_req;
        logic       dm_we;
        logic [7:0] dm_addr;
        logic [7:0] dm_wdata;
        logic       hlt;
        logic       int_in;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       hlt;
    logic       int_in;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       pc_load;
    logic [7:0] pc_vec;
    logic       int_ack;
`ifdef MEM_ACCESS_STATS_EN
    logic [15:0] stat_if_stall;
    logic [15:0] stat_dm_acc;
    logic [7:0]  stat_int;
    int          m_stat_dm;
    int          m_stat_int;
`endif

    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    mem_access_ctrl #(
        .ADDR_W       (8),
        .DATA_W       (8),
        .MAX_STARVE   (MAX_STARVE),
        .RST_VEC_ADDR (RST_VEC),
        .INT_VEC_ADDR (INT_VEC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .hlt          (hlt),
        .int_in       (int_in),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
`ifdef MEM_ACCESS_STATS_EN
        .stat_if_stall(stat_if_stall),
        .stat_dm_acc  (stat_dm_acc),
        .stat_int     (stat_int),
`endif
        .pc_load      (pc_load),
        .pc_vec       (pc_vec),
        .int_ack      (int_ack)
    );

    // Unified 256x8 memory with synchronous read, old data on read-during-write.
    logic [7:0] tb_mem [256];
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr] <= mem_wdata;
        mem_rdata <= tb_mem[mem_addr];
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: vector work left to do, pending interrupt, fetch denial run.
    logic [7:0] m_mem [256];
    int         m_busy;
    logic       m_pend;
    int         m_denied;
    logic [7:0] m_last;
    logic [7:0] m_vec;
    logic       m_pcl;
    logic [7:0] m_pcv;
    logic       m_ifv;
    logic       m_dmv;
    logic [7:0] m_rd;

    task automatic model_reset();
        m_busy   = 2;
        m_pend   = 1'b0;
        m_denied = 0;
        m_last   = 8'h00;
        m_pcl    = 1'b0;
        m_pcv    = 8'h00;
        m_ifv    = 1'b0;
        m_dmv    = 1'b0;
`ifdef MEM_ACCESS_STATS_EN
        m_stat_dm  = 0;
        m_stat_int = 0;
`endif
    endtask

    function automatic stim_t idle();
        stim_t s;
        s     = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    task automatic step(input stim_t s, input bit abort);
        logic       e_ifg, e_dmg, e_we, e_ack, e_stif, fetch_ok;
        logic [7:0] e_addr;
        @(negedge clk);
        rst          = s.rst;
        bus.if_req   = s.if_req;
        bus.if_addr  = s.if_addr;
        bus.dm_req   = s.dm_req;
        bus.dm_we    = s.dm_we;
        bus.dm_addr  = s.dm_addr;
        bus.dm_wdata = s.dm_wdata;
        hlt          = s.hlt;
        int_in       = s.int_in;
        if (!s.rst) model_reset();
        #2;

        e_ifg = 1'b0; e_dmg = 1'b0; e_we = 1'b0; e_ack = 1'b0; e_addr = m_last;
        if (m_busy == 2) begin
            e_addr = RST_VEC;
        end else if (m_busy == 1) begin
            e_addr = m_last;
        end else if (m_pend && !s.dm_req) begin
            e_addr = INT_VEC;
            e_ack  = 1'b1;
        end else begin
            fetch_ok = s.if_req && !s.hlt;
            e_ifg    = fetch_ok && (!s.dm_req || m_denied >= MAX_STARVE);
            e_dmg    = s.dm_req && !e_ifg;
            if (e_dmg) begin
                e_addr = s.dm_addr;
                e_we   = s.dm_we;
            end else if (e_ifg) begin
                e_addr = s.if_addr;
            end
        end
        e_stif = (m_busy != 0) || e_ack || (s.if_req && !e_ifg);

        check("if_gnt",    16'(bus.if_gnt),    16'(e_ifg));
        check("dm_gnt",    16'(bus.dm_gnt),    16'(e_dmg));
        check("stall_if",  16'(bus.stall_if),  16'(e_stif));
        check("stall_mem", 16'(bus.stall_mem), 16'(s.dm_req && !e_dmg));
        check("mem_we",    16'(mem_we),        16'(e_we));
        check("mem_addr",  16'(mem_addr),      16'(e_addr));
        check("int_ack",   16'(int_ack),       16'(e_ack));
        check("pc_load",   16'(pc_load),       16'(m_pcl));
        check("pc_vec",    16'(pc_vec),        16'(m_pcv));
        check("if_rvalid", 16'(bus.if_rvalid), 16'(m_ifv));
        check("dm_rvalid", 16'(bus.dm_rvalid), 16'(m_dmv));
        if (m_ifv || m_dmv) check("mem_rdata", 16'(mem_rdata), 16'(m_rd));
        if (e_we) check("mem_wdata", 16'(mem_wdata), 16'(s.dm_wdata));

        if (abort) begin
            rst = 1'b0;
            #1;
            check("abort_mem_we",   16'(mem_we),       16'(0));
            check("abort_mem_addr", 16'(mem_addr),     16'(RST_VEC));
            check("abort_dm_gnt",   16'(bus.dm_gnt),   16'(0));
            check("abort_stall_if", 16'(bus.stall_if), 16'(1));
            model_reset();
        end else if (s.rst) begin
`ifdef MEM_ACCESS_STATS_EN
            if (e_dmg) m_stat_dm++;
            if (e_ack) m_stat_int++;
`endif
            if (m_busy == 2 || e_ack || e_ifg || e_dmg) m_last = e_addr;
            m_rd  = m_mem[e_addr];
            m_ifv = e_ifg;
            m_dmv = e_dmg && !s.dm_we;
            m_pcl = (m_busy == 1);
            if (m_busy == 1) m_pcv = m_vec;
            if (m_busy == 2 || e_ack) m_vec = m_mem[e_addr];
            if (e_we) m_mem[e_addr] = s.dm_wdata;
            if (m_busy > 0) m_busy--;
            else if (e_ack) m_busy = 1;
            m_pend = e_ack ? 1'b0 : (m_pend | s.int_in);
            if (e_ifg || !s.if_req) m_denied = 0;
            else if (!s.hlt && m_denied < MAX_STARVE) m_denied++;
        end
    endtask

    initial begin
        stim_t s;
        for (int i = 0; i < 256; i++) begin
            tb_mem[i] = 8'($urandom);
            m_mem[i]  = tb_mem[i];
        end
        tb_mem[8'h00] = 8'h02; m_mem[8'h00] = 8'h02;
        tb_mem[8'h01] = 8'h80; m_mem[8'h01] = 8'h80;
        tb_mem[8'h40] = 8'h43; m_mem[8'h40] = 8'h43;
        rst = 1'b0; hlt = 1'b0; int_in = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.dm_req = 1'b0;
        bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        model_reset();

        // Reset held three cycles, then vector fetch from Mem[0].
        s = idle(); s.rst = 1'b0; s.if_req = 1'b1; s.dm_req = 1'b1;
        repeat (3) step(s, 0);
        check("rst_mem_addr", 16'(mem_addr), 16'(0));
        check("rst_pc_vec",   16'(pc_vec),   16'(0));
        check("rst_stall_if", 16'(bus.stall_if), 16'(1));
        s = idle();
        repeat (3) step(s, 0);
        check("tp1_pc_load", 16'(pc_load), 16'(1));
        check("tp1_pc_vec",  16'(pc_vec),  16'(8'h02));
        s.if_req = 1'b1; s.if_addr = 8'h02;
        step(s, 0);
        check("tp1_if_gnt",   16'(bus.if_gnt), 16'(1));
        check("tp1_mem_addr", 16'(mem_addr),   16'(8'h02));

        // Data read beats fetch; data returns next cycle.
        s = idle(); s.if_req = 1'b1; s.if_addr = 8'h03; s.dm_req = 1'b1; s.dm_addr = 8'h40;
        step(s, 0);
        check("tp2_dm_gnt",   16'(bus.dm_gnt),   16'(1));
        check("tp2_stall_if", 16'(bus.stall_if), 16'(1));
        step(idle(), 0);
        check("tp2_dm_rvalid", 16'(bus.dm_rvalid), 16'(1));
        check("tp2_rdata",     16'(mem_rdata),     16'(8'h43));

        // Starvation: four data grants, then one forced fetch, repeating.
        for (int i = 0; i < 10; i++) begin
            s = idle(); s.if_req = 1'b1; s.if_addr = 8'(8'h10 + i);
            s.dm_req = 1'b1; s.dm_addr = 8'($urandom);
            step(s, 0);
            check("tp3_if_gnt",    16'(bus.if_gnt),    16'(i % 5 == 4));
            check("tp3_stall_mem", 16'(bus.stall_mem), 16'(i % 5 == 4));
        end

        // Interrupt waits for the first cycle without a data request.
        step(idle(), 0);
        s = idle(); s.int_in = 1'b1; s.dm_req = 1'b1; s.dm_addr = 8'h20;
        step(s, 0);
        check("tp4_ack_a", 16'(int_ack), 16'(0));
        s.int_in = 1'b0;
        step(s, 0);
        check("tp4_ack_b", 16'(int_ack), 16'(0));
        s = idle(); s.if_req = 1'b1; s.if_addr = 8'h21;
        step(s, 0);
        check("tp4_ack",      16'(int_ack),  16'(1));
        check("tp4_vec_addr", 16'(mem_addr), 16'(INT_VEC));
        step(idle(), 0);
        step(idle(), 0);
        check("tp4_pc_load", 16'(pc_load), 16'(1));
        check("tp4_pc_vec",  16'(pc_vec),  16'(8'h80));

        // Halted: no fetch grants, data still served, interrupt still taken.
        s = idle(); s.hlt = 1'b1; s.if_req = 1'b1; s.if_addr = 8'h30;
        s.dm_req = 1'b1; s.dm_we = 1'b1; s.dm_addr = 8'hF0; s.dm_wdata = 8'h55;
        step(s, 0);
        check("tp5_if_gnt", 16'(bus.if_gnt), 16'(0));
        check("tp5_mem_we", 16'(mem_we),     16'(1));
        s.dm_req = 1'b0; s.dm_we = 1'b0; s.int_in = 1'b1;
        step(s, 0);
        check("tp5_mem_f0", 16'(tb_mem[8'hF0]), 16'(8'h55));
        s.int_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(s, 0);
            check("tp5_if_gnt_hlt", 16'(bus.if_gnt), 16'(0));
        end
        check("tp5_pc_load", 16'(pc_load), 16'(1));

        // Reset during a write grant: write dropped, vector re-read.
        s = idle(); s.dm_req = 1'b1; s.dm_we = 1'b1; s.dm_addr = 8'h00; s.dm_wdata = 8'h33;
        step(s, 0);
        s.dm_addr = 8'hF8; s.dm_wdata = ~m_mem[8'hF8];
        step(s, 1);
        s = idle(); s.rst = 1'b0;
        repeat (2) step(s, 0);
        check("tp6_no_write", 16'(tb_mem[8'hF8]), 16'(m_mem[8'hF8]));
        repeat (3) step(idle(), 0);
        check("tp6_pc_load", 16'(pc_load), 16'(1));
        check("tp6_pc_vec",  16'(pc_vec),  16'(8'h33));

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            s.rst      = ($urandom_range(0, 399) != 0);
            s.if_req   = ($urandom_range(0, 9) < 7);
            s.if_addr  = 8'($urandom);
            s.dm_req   = ($urandom_range(0, 9) < 5);
            s.dm_we    = ($urandom_range(0, 9) < 3);
            s.dm_addr  = 8'($urandom);
            s.dm_wdata = 8'($urandom);
            s.hlt      = ($urandom_range(0, 9) == 0);
            s.int_in   = ($urandom_range(0, 29) == 0);
            step(s, 0);
        end

`ifdef MEM_ACCESS_STATS_EN
        check("stat_dm_acc", stat_dm_acc, 16'((m_stat_dm > 65535) ? 65535 : m_stat_dm));
        check("stat_int",    16'(stat_int), 16'((m_stat_int > 255) ? 255 : m_stat_int));
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
